// File: rtl/useq_clkgen_pkg.sv
// Shared definitions for the microsequencer clock-enable generator: state encoding,
// default bus timeout and the post-completion state selection.
package useq_clkgen_pkg;

  typedef enum logic [1:0] {
    StRun  = 2'b00,
    StWait = 2'b01,
    StHalt = 2'b10
  } useq_state_e;

  localparam int unsigned TimeoutDefault = 127;

  // After a microword executes, stop again if single-stepping at console level or on a one-shot step.
  function automatic useq_state_e after_exec_state(logic step_en, logic one_shot);
    return (step_en | one_shot) ? StHalt : StRun;
  endfunction

endpackage

// File: rtl/useq_clkgen.sv
// KS10 microsequencer clock enable: stalls on outstanding bus cycles, times out hung
// cycles as NXM, and implements console micro-breakpoint and single-step halting.
module useq_clkgen
  import useq_clkgen_pkg::*;
#(
  parameter int unsigned TIMEOUT = TimeoutDefault,
  parameter int unsigned CNTW    = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cromMEMWAIT,
  input  logic            busACK,
  input  logic [0:11]     uaddr,
  input  logic            brkEN,
  input  logic [0:11]     brkADDR,
  input  logic            stepEN,
  input  logic            stepREQ,
  input  logic            contREQ,
  output logic            clken,
  output logic            halted,
  output logic            busNXM,
  output logic [CNTW-1:0] waitCNT
);

  localparam logic [CNTW-1:0] TimeoutCnt = CNTW'(TIMEOUT);

  useq_state_e     r_state, w_state_next;
  logic [CNTW-1:0] r_wait_cnt, w_wait_cnt_next;
  logic            r_one_shot, w_one_shot_next;
  logic            r_skip_brk, w_skip_brk_next;
  logic            w_brk_hit;
  logic            w_clken;
  logic            w_nxm;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StRun;
      r_wait_cnt <= '0;
      r_one_shot <= 1'b0;
      r_skip_brk <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
      r_one_shot <= w_one_shot_next;
      r_skip_brk <= w_skip_brk_next;
    end
  end

  assign w_brk_hit = brkEN & (uaddr == brkADDR) & ~r_skip_brk;

  always_comb begin
    w_state_next    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    w_one_shot_next = r_one_shot;
    w_skip_brk_next = r_skip_brk;
    w_clken         = 1'b0;
    w_nxm           = 1'b0;
    case (r_state)
      StRun: begin
        if (w_brk_hit) begin
          w_state_next = StHalt;
        end else if (cromMEMWAIT && !busACK) begin
          w_state_next    = StWait;
          w_wait_cnt_next = CNTW'(1);
        end else begin
          w_clken      = 1'b1;
          w_state_next = after_exec_state(stepEN, r_one_shot);
        end
      end
      StWait: begin
        if (busACK) begin
          w_clken         = 1'b1;
          w_wait_cnt_next = '0;
          w_state_next    = after_exec_state(stepEN, r_one_shot);
        end else if (r_wait_cnt == TimeoutCnt) begin
          w_nxm           = 1'b1;
          w_clken         = 1'b1;
          w_wait_cnt_next = '0;
          w_state_next    = after_exec_state(stepEN, r_one_shot);
        end else begin
          w_wait_cnt_next = r_wait_cnt + CNTW'(1);
        end
      end
      StHalt: begin
        // skipBrk lets the halted-on microword execute once without re-breaking.
        if (stepREQ) begin
          w_state_next    = StRun;
          w_one_shot_next = 1'b1;
          w_skip_brk_next = 1'b1;
        end else if (contREQ) begin
          w_state_next    = StRun;
          w_one_shot_next = 1'b0;
          w_skip_brk_next = 1'b1;
        end
      end
      default: begin
        w_state_next = StRun;
      end
    endcase
    if (w_clken) begin
      w_one_shot_next = 1'b0;
      w_skip_brk_next = 1'b0;
    end
  end

  // Reset forces execution of word 0000 and suppresses any stale timeout indication.
  assign clken   = w_clken | rst;
  assign busNXM  = w_nxm & ~rst;
  assign halted  = (r_state == StHalt);
  assign waitCNT = r_wait_cnt;

endmodule

// File: tb/tb_useq_clkgen.sv
// Self-checking bench for useq_clkgen: directed scenarios plus randomized traffic,
// all compared against a cycle-level behavioural model of the clock-enable rules.
module tb_useq_clkgen;

  localparam int unsigned TIMEOUT = 127;
  localparam int unsigned CNTW    = 8;

  logic            clk = 1'b0;
  logic            rst, cromMEMWAIT, busACK, brkEN, stepEN, stepREQ, contREQ;
  logic [0:11]     uaddr, brkADDR;
  logic            clken, halted, busNXM;
  logic [CNTW-1:0] waitCNT;

  always #5 clk = ~clk;

  useq_clkgen #(
    .TIMEOUT(TIMEOUT),
    .CNTW   (CNTW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cromMEMWAIT(cromMEMWAIT),
    .busACK     (busACK),
    .uaddr      (uaddr),
    .brkEN      (brkEN),
    .brkADDR    (brkADDR),
    .stepEN     (stepEN),
    .stepREQ    (stepREQ),
    .contREQ    (contREQ),
    .clken      (clken),
    .halted     (halted),
    .busNXM     (busNXM),
    .waitCNT    (waitCNT)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: halted flag, cycles spent waiting on the bus (0 = not waiting), step/skip flags.
  bit m_halted = 0, m_oneshot = 0, m_skip = 0;
  int m_waited = 0;
  bit n_halted, n_oneshot, n_skip;
  int n_waited;
  bit e_clken, e_halted, e_nxm;
  int e_cnt;

  // Stimulus-side microsequencer: advances on every expected clock enable.
  logic [0:11] pc       = '0;
  logic [0:11] loop_addr = 12'hfff;

  task automatic model_eval();
    bit done;
    done      = 0;
    e_halted  = m_halted;
    e_cnt     = m_waited;
    e_nxm     = 0;
    e_clken   = 0;
    n_halted  = m_halted;
    n_waited  = m_waited;
    n_oneshot = m_oneshot;
    n_skip    = m_skip;
    if (rst) begin
      e_clken = 1; n_halted = 0; n_waited = 0; n_oneshot = 0; n_skip = 0;
    end else if (m_halted) begin
      if (stepREQ) begin
        n_halted = 0; n_oneshot = 1; n_skip = 1;
      end else if (contREQ) begin
        n_halted = 0; n_oneshot = 0; n_skip = 1;
      end
    end else if (m_waited > 0) begin
      if (busACK) done = 1;
      else if (m_waited == TIMEOUT) begin
        done = 1; e_nxm = 1;
      end else n_waited = m_waited + 1;
    end else if (brkEN && uaddr == brkADDR && !m_skip) begin
      n_halted = 1;
    end else if (cromMEMWAIT && !busACK) begin
      n_waited = 1;
    end else begin
      done = 1;
    end
    if (done) begin
      e_clken   = 1;
      n_waited  = 0;
      n_halted  = stepEN || m_oneshot;
      n_oneshot = 0;
      n_skip    = 0;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    m_halted  = n_halted;
    m_waited  = n_waited;
    m_oneshot = n_oneshot;
    m_skip    = n_skip;
    if (rst) pc = '0;
    else if (e_clken && pc != loop_addr) pc = pc + 12'd1;
    #1;
    uaddr = pc;
  endtask

  task automatic test_reset();
    rst = 1; cromMEMWAIT = 1; busACK = 0; brkEN = 0; brkADDR = '0;
    stepEN = 0; stepREQ = 0; contREQ = 0; uaddr = '0;
    model_eval();
    advance();
    for (int i = 0; i < 3; i++) begin
      model_eval(); #4;
      n_tests++;
      if ({clken, halted, busNXM, waitCNT} !== {e_clken, e_halted, e_nxm, CNTW'(e_cnt)}) begin
        n_fail++;
        $display("FAIL reset_model cyc=%0d got %b%b%b cnt=%0d want %b%b%b cnt=%0d", i,
                 clken, halted, busNXM, waitCNT, e_clken, e_halted, e_nxm, e_cnt);
      end
      n_tests++;
      if (clken !== 1'b1 || halted !== 1'b0 || busNXM !== 1'b0 || waitCNT !== '0) begin
        n_fail++;
        $display("FAIL reset_values cyc=%0d got clken=%b halted=%b nxm=%b cnt=%0d want 1 0 0 0",
                 i, clken, halted, busNXM, waitCNT);
      end
      advance();
    end
    rst = 0; cromMEMWAIT = 0;
    model_eval(); #4;
    n_tests++;
    if (clken !== 1'b1 || halted !== 1'b0 || waitCNT !== '0) begin
      n_fail++;
      $display("FAIL reset_exit got clken=%b halted=%b cnt=%0d want 1 0 0", clken, halted, waitCNT);
    end
    advance();
  endtask

  task automatic test_mem_wait();
    int zeros = 0, nxm = 0;
    cromMEMWAIT = 1;
    for (int i = 0; i < 6; i++) begin
      busACK = (i == 5);
      model_eval(); #4;
      n_tests++;
      if ({clken, halted, busNXM, waitCNT} !== {e_clken, e_halted, e_nxm, CNTW'(e_cnt)}) begin
        n_fail++;
        $display("FAIL mem_wait cyc=%0d got %b%b%b cnt=%0d want %b%b%b cnt=%0d", i,
                 clken, halted, busNXM, waitCNT, e_clken, e_halted, e_nxm, e_cnt);
      end
      if (i > 0) begin
        n_tests++;
        if (waitCNT !== CNTW'(i)) begin
          n_fail++;
          $display("FAIL mem_wait_count cyc=%0d got %0d want %0d", i, waitCNT, i);
        end
      end
      if (clken === 1'b0) zeros++;
      if (busNXM === 1'b1) nxm++;
      advance();
    end
    busACK = 0; cromMEMWAIT = 0;
    n_tests++;
    if (zeros != 5 || nxm != 0) begin
      n_fail++;
      $display("FAIL mem_wait_summary got stalls=%0d nxm=%0d want 5 0", zeros, nxm);
    end
  endtask

  task automatic test_timeout(input bit ack_on_timeout);
    int zeros = 0, nxm = 0;
    bit fin = 0;
    cromMEMWAIT = 1;
    for (int i = 0; i < int'(TIMEOUT) + 10 && !fin; i++) begin
      busACK = ack_on_timeout && (m_waited == TIMEOUT);
      model_eval(); #4;
      n_tests++;
      if ({clken, halted, busNXM, waitCNT} !== {e_clken, e_halted, e_nxm, CNTW'(e_cnt)}) begin
        n_fail++;
        $display("FAIL timeout ack=%0d cyc=%0d got %b%b%b cnt=%0d want %b%b%b cnt=%0d",
                 ack_on_timeout, i, clken, halted, busNXM, waitCNT, e_clken, e_halted, e_nxm,
                 e_cnt);
      end
      if (clken === 1'b0) zeros++;
      if (busNXM === 1'b1) nxm++;
      if (e_clken) fin = 1;
      advance();
    end
    busACK = 0; cromMEMWAIT = 0;
    n_tests++;
    if (!fin || zeros != int'(TIMEOUT) || nxm != (ack_on_timeout ? 0 : 1)) begin
      n_fail++;
      $display("FAIL timeout_summary ack=%0d got stalls=%0d nxm=%0d want %0d %0d",
               ack_on_timeout, zeros, nxm, TIMEOUT, ack_on_timeout ? 0 : 1);
    end
  endtask

  task automatic test_breakpoint();
    int ones = 0;
    brkEN = 1; brkADDR = 12'o0100; pc = 12'o0074; uaddr = pc;
    for (int i = 0; i < 14; i++) begin
      contREQ = (i == 8);
      model_eval(); #4;
      n_tests++;
      if ({clken, halted, busNXM, waitCNT} !== {e_clken, e_halted, e_nxm, CNTW'(e_cnt)}) begin
        n_fail++;
        $display("FAIL breakpoint cyc=%0d got %b%b%b cnt=%0d want %b%b%b cnt=%0d", i,
                 clken, halted, busNXM, waitCNT, e_clken, e_halted, e_nxm, e_cnt);
      end
      if (i == 6) begin
        n_tests++;
        if (halted !== 1'b1 || clken !== 1'b0) begin
          n_fail++;
          $display("FAIL brk_halt got halted=%b clken=%b want 1 0", halted, clken);
        end
      end
      if (i >= 9 && clken === 1'b1) ones++;
      advance();
    end
    contREQ = 0;
    n_tests++;
    if (ones != 5) begin
      n_fail++;
      $display("FAIL brk_resume got executed=%0d want 5", ones);
    end
    // Self-looping microword at the breakpoint must re-halt after one execution.
    ones = 0; loop_addr = 12'o0100; pc = 12'o0077; uaddr = pc;
    for (int i = 0; i < 6; i++) begin
      contREQ = (i == 2);
      model_eval(); #4;
      n_tests++;
      if ({clken, halted, busNXM, waitCNT} !== {e_clken, e_halted, e_nxm, CNTW'(e_cnt)}) begin
        n_fail++;
        $display("FAIL brk_loop cyc=%0d got %b%b%b cnt=%0d want %b%b%b cnt=%0d", i,
                 clken, halted, busNXM, waitCNT, e_clken, e_halted, e_nxm, e_cnt);
      end
      if (clken === 1'b1) ones++;
      if (i == 5) begin
        n_tests++;
        if (ones != 2 || halted !== 1'b1) begin
          n_fail++;
          $display("FAIL brk_rehalt got executed=%0d halted=%b want 2 1", ones, halted);
        end
      end
      advance();
    end
    brkEN = 0; loop_addr = 12'hfff; contREQ = 1;
    model_eval();
    advance();
    contREQ = 0;
  endtask

  task automatic test_step();
    int ones = 0;
    stepEN = 1;
    for (int i = 0; i < 14; i++) begin
      stepREQ = (i == 2 || i == 5 || i == 8 || i == 11);
      contREQ = (i == 11);
      if (i == 10) stepEN = 0;
      model_eval(); #4;
      n_tests++;
      if ({clken, halted, busNXM, waitCNT} !== {e_clken, e_halted, e_nxm, CNTW'(e_cnt)}) begin
        n_fail++;
        $display("FAIL step cyc=%0d got %b%b%b cnt=%0d want %b%b%b cnt=%0d", i,
                 clken, halted, busNXM, waitCNT, e_clken, e_halted, e_nxm, e_cnt);
      end
      if (i > 0 && clken === 1'b1) ones++;
      if (i == 4 || i == 7 || i == 10 || i == 13) begin
        n_tests++;
        if (halted !== 1'b1) begin
          n_fail++;
          $display("FAIL step_between cyc=%0d got halted=%b want 1", i, halted);
        end
      end
      advance();
    end
    stepREQ = 0; contREQ = 0;
    n_tests++;
    if (ones != 4) begin
      n_fail++;
      $display("FAIL step_count got executed=%0d want 4", ones);
    end
  endtask

  task automatic test_step_wait();
    int ones = 0;
    for (int i = 0; i < 7; i++) begin
      stepREQ     = (i == 0);
      cromMEMWAIT = 1;
      busACK      = (i == 5);
      model_eval(); #4;
      n_tests++;
      if ({clken, halted, busNXM, waitCNT} !== {e_clken, e_halted, e_nxm, CNTW'(e_cnt)}) begin
        n_fail++;
        $display("FAIL step_wait cyc=%0d got %b%b%b cnt=%0d want %b%b%b cnt=%0d", i,
                 clken, halted, busNXM, waitCNT, e_clken, e_halted, e_nxm, e_cnt);
      end
      if (clken === 1'b1) ones++;
      advance();
    end
    n_tests++;
    if (ones != 1 || halted !== 1'b1) begin
      n_fail++;
      $display("FAIL step_wait_summary got executed=%0d halted=%b want 1 1", ones, halted);
    end
    stepREQ = 0; busACK = 0; cromMEMWAIT = 0; contREQ = 1;
    model_eval();
    advance();
    contREQ = 0;
  endtask

  task automatic test_random();
    loop_addr = 12'd7;
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 99) == 0);
      cromMEMWAIT = ($urandom_range(0, 2) == 0);
      busACK      = ($urandom_range(0, 3) == 0);
      brkEN       = 1'($urandom_range(0, 1));
      stepREQ     = ($urandom_range(0, 5) == 0);
      contREQ     = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 15) == 0) brkADDR = 12'($urandom_range(0, 15));
      if ($urandom_range(0, 31) == 0) stepEN = ~stepEN;
      if ($urandom_range(0, 7) == 0) begin
        pc    = 12'($urandom_range(0, 15));
        uaddr = pc;
      end
      model_eval(); #4;
      n_tests++;
      if ({clken, halted, busNXM, waitCNT} !== {e_clken, e_halted, e_nxm, CNTW'(e_cnt)}) begin
        n_fail++;
        $display("FAIL random cyc=%0d got %b%b%b cnt=%0d want %b%b%b cnt=%0d", i,
                 clken, halted, busNXM, waitCNT, e_clken, e_halted, e_nxm, e_cnt);
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_mem_wait();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_breakpoint();
    test_step();
    test_step_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
